move_input_ctrl: RTL and testbench

- Sits directly downstream of the button debouncer and turns its active-low one-cycle press pulses into Connect Four moves.
- Keeps the player's cursor column, skipping full columns and wrapping at the edges.
- Sends the chosen column to the board/game engine over a valid/ready handshake, then toggles the current player.

---
 rtl/c4_pkg.sv | 21 ++
 rtl/move_input_ctrl_if.sv | 23 ++
 rtl/c4_col_search.sv | 44 ++++
 rtl/move_input_ctrl.sv | 125 ++++++++++++
 tb/tb_move_input_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/c4_pkg.sv
// Shared constants and types for the Connect Four move-input path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: board geometry, button bit positions, controller state encoding.
package c4_pkg;

    localparam int N_COLS    = 7;
    localparam int COL_W     = 3;   // 2**COL_W must be >= N_COLS
    localparam int START_COL = 3;
    localparam int N_BUTTONS = 3;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_DROP  = 2;

    typedef enum logic {
        ST_SELECT = 1'b0,
        ST_DROP   = 1'b1
    } state_t;

endpackage

// File: rtl/move_input_ctrl_if.sv
// Drop request channel from the move-input controller to the board engine.
// Latency: n/a (wires only).
// Backpressure: valid/ready; request held with a stable column until ready.
// Signals: drop_valid (request pending), drop_col (column), drop_ready (accept).
interface move_input_ctrl_if #(
    parameter int COL_W = c4_pkg::COL_W
);
    logic             drop_valid;
    logic [COL_W-1:0] drop_col;
    logic             drop_ready;

    modport master (
        output drop_valid,
        output drop_col,
        input  drop_ready
    );

    modport slave (
        input  drop_valid,
        input  drop_col,
        output drop_ready
    );
endinterface

// File: rtl/c4_col_search.sv
// Finds the nearest non-full column from a start column in one direction, with wrap.
// Latency: combinational.
// Backpressure: none.
// Ports: start_col, dir_right (1 = increasing index), col_full in; found_col, found out.
module c4_col_search #(
    parameter int N_COLS = c4_pkg::N_COLS,
    parameter int COL_W  = c4_pkg::COL_W
) (
    input  logic [COL_W-1:0]  start_col,
    input  logic              dir_right,
    input  logic [N_COLS-1:0] col_full,
    output logic [COL_W-1:0]  found_col,
    output logic              found
);

    // One extra bit so start + offset (< 2*N_COLS) never overflows before the
    // modulo-N_COLS fold.
    typedef logic [COL_W:0] ext_t;

    ext_t cand;

    // Walk offsets from farthest to nearest so the nearest free column is the
    // last one written; the start column itself is never a candidate.
    always_comb begin
        found     = 1'b0;
        found_col = start_col;
        cand      = '0;
        for (int k = N_COLS - 1; k >= 1; k--) begin
            if (dir_right) begin
                cand = ext_t'(start_col) + ext_t'(k);
            end else begin
                cand = ext_t'(start_col) + ext_t'(N_COLS - k);
            end
            if (cand >= ext_t'(N_COLS)) begin
                cand = cand - ext_t'(N_COLS);
            end
            if (!col_full[cand[COL_W-1:0]]) begin
                found     = 1'b1;
                found_col = cand[COL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/move_input_ctrl.sv
// Turns debounced active-low button pulses into cursor moves and column drop requests.
// Latency: press -> cursor/drop_valid 1 cycle; drop_ready -> move_done 1 cycle.
// Backpressure: drop request held stable until drop_ready; presses ignored while waiting.
// Ports: clk, rst (sync, active-high), btns_in, game_active, col_full in;
//        cursor_col, player, move_done out; drop (master side of the drop channel).
module move_input_ctrl #(
    parameter int N_COLS    = c4_pkg::N_COLS,
    parameter int COL_W     = c4_pkg::COL_W,
    parameter int START_COL = c4_pkg::START_COL,
    parameter int N_BUTTONS = c4_pkg::N_BUTTONS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] btns_in,
    input  logic                 game_active,
    input  logic [N_COLS-1:0]    col_full,
    output logic [COL_W-1:0]     cursor_col,
    output logic                 player,
    output logic                 move_done,
    move_input_ctrl_if.master    drop
);
    import c4_pkg::*;

    state_t           state_q, state_d;
    logic [COL_W-1:0] cursor_q, cursor_d;
    logic             player_q, player_d;
    logic             valid_q, valid_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             done_q, done_d;

    logic             press_left, press_right, press_drop;
    logic [COL_W-1:0] left_col, right_col;
    logic             left_found, right_found;

    // Debouncer already emits single-cycle pulses, so a plain inversion is enough.
    assign press_left  = ~btns_in[BTN_LEFT];
    assign press_right = ~btns_in[BTN_RIGHT];
    assign press_drop  = ~btns_in[BTN_DROP];

    c4_col_search #(.N_COLS(N_COLS), .COL_W(COL_W)) u_search_left (
        .start_col (cursor_q),
        .dir_right (1'b0),
        .col_full  (col_full),
        .found_col (left_col),
        .found     (left_found)
    );

    // Also serves auto-advance, which always searches rightward.
    c4_col_search #(.N_COLS(N_COLS), .COL_W(COL_W)) u_search_right (
        .start_col (cursor_q),
        .dir_right (1'b1),
        .col_full  (col_full),
        .found_col (right_col),
        .found     (right_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SELECT;
            cursor_q <= COL_W'(START_COL);
            player_q <= 1'b0;
            valid_q  <= 1'b0;
            col_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            player_q <= player_d;
            valid_q  <= valid_d;
            col_q    <= col_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        player_d = player_q;
        valid_d  = valid_q;
        col_d    = col_q;
        done_d   = 1'b0;

        case (state_q)
            ST_SELECT: begin
                if (game_active) begin
                    if (press_drop) begin
                        // Drop wins over any simultaneous left/right press.
                        if (!col_full[cursor_q]) begin
                            col_d   = cursor_q;
                            valid_d = 1'b1;
                            state_d = ST_DROP;
                        end
                    end else if (press_left && press_right) begin
                        // Contradictory input: hold.
                    end else if (press_left) begin
                        if (left_found) cursor_d = left_col;
                    end else if (press_right) begin
                        if (right_found) cursor_d = right_col;
                    end else if (col_full[cursor_q] && right_found) begin
                        // Keep the cursor off full columns when the player is idle.
                        cursor_d = right_col;
                    end
                end
            end
            ST_DROP: begin
                // Request is never withdrawn; presses and game_active are ignored.
                if (drop.drop_ready) begin
                    valid_d  = 1'b0;
                    done_d   = 1'b1;
                    player_d = ~player_q;
                    cursor_d = COL_W'(START_COL);
                    state_d  = ST_SELECT;
                end
            end
            default: state_d = ST_SELECT;
        endcase
    end

    assign cursor_col      = cursor_q;
    assign player          = player_q;
    assign move_done       = done_q;
    assign drop.drop_valid = valid_q;
    assign drop.drop_col   = col_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
module tb_move_input_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btns_in;
    logic       game_active;
    logic [6:0] col_full;
    logic [2:0] cursor_col;
    logic       player;
    logic       move_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [2:0] cursor;
        logic       player;
        logic       valid;
        logic [2:0] col;
        logic       col_chk;
        logic       done;
    } exp_t;

    exp_t sb[$];

    move_input_ctrl_if #(.COL_W(3)) dif ();

    move_input_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .btns_in     (btns_in),
        .game_active (game_active),
        .col_full    (col_full),
        .cursor_col  (cursor_col),
        .player      (player),
        .move_done   (move_done),
        .drop        (dif)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] IDLE  = 3'b111;
    localparam logic [2:0] LEFT  = 3'b110;
    localparam logic [2:0] RIGHT = 3'b101;
    localparam logic [2:0] DROP  = 3'b011;
    localparam logic [2:0] LR    = 3'b100;
    localparam logic [2:0] LD    = 3'b010;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then
    // pop and compare one sample after the edge.
    task automatic step(input string name, input logic r, input logic [2:0] b,
                        input logic ga, input logic [6:0] full, input logic rdy,
                        input logic [2:0] e_cur, input logic e_pl, input logic e_vld,
                        input logic [2:0] e_col, input logic e_done);
        exp_t e;
        exp_t got;
        rst            = r;
        btns_in        = b;
        game_active    = ga;
        col_full       = full;
        dif.drop_ready = rdy;
        e.name    = name;
        e.cursor  = e_cur;
        e.player  = e_pl;
        e.valid   = e_vld;
        e.col     = e_col;
        e.col_chk = e_vld;
        e.done    = e_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        cmp({got.name, ".cursor"}, 8'(cursor_col), 8'(got.cursor));
        cmp({got.name, ".player"}, 8'(player), 8'(got.player));
        cmp({got.name, ".valid"}, 8'(dif.drop_valid), 8'(got.valid));
        if (got.col_chk) cmp({got.name, ".col"}, 8'(dif.drop_col), 8'(got.col));
        cmp({got.name, ".done"}, 8'(move_done), 8'(got.done));
    endtask

    initial begin
        rst = 1'b1; btns_in = IDLE; game_active = 1'b1; col_full = '0; dif.drop_ready = 1'b0;

        // Reset state
        step("reset0", 1, IDLE, 1, 7'h00, 0, 3, 0, 0, 0, 0);
        step("reset1", 1, LEFT, 1, 7'h00, 0, 3, 0, 0, 0, 0);

        // Left wrap, then right wrap back to 3
        step("left1", 0, LEFT, 1, 7'h00, 0, 2, 0, 0, 0, 0);
        step("left2", 0, LEFT, 1, 7'h00, 0, 1, 0, 0, 0, 0);
        step("left3", 0, LEFT, 1, 7'h00, 0, 0, 0, 0, 0, 0);
        step("left4", 0, LEFT, 1, 7'h00, 0, 6, 0, 0, 0, 0);
        step("right_wrap", 0, RIGHT, 1, 7'h00, 0, 0, 0, 0, 0, 0);
        step("right1", 0, RIGHT, 1, 7'h00, 0, 1, 0, 0, 0, 0);
        step("right2", 0, RIGHT, 1, 7'h00, 0, 2, 0, 0, 0, 0);
        step("right3", 0, RIGHT, 1, 7'h00, 0, 3, 0, 0, 0, 0);

        // Skip a full column both ways
        step("skip_right", 0, RIGHT, 1, 7'b0010000, 0, 5, 0, 0, 0, 0);
        step("skip_left", 0, LEFT, 1, 7'b0010000, 0, 3, 0, 0, 0, 0);

        // Handshake stall with ignored presses, then completion
        step("drop", 0, DROP, 1, 7'h00, 0, 3, 0, 1, 3, 0);
        for (int i = 0; i < 5; i++) begin
            step("stall", 0, (i % 2 == 0) ? LEFT : RIGHT, 1, 7'h00, 0, 3, 0, 1, 3, 0);
        end
        step("accept", 0, IDLE, 1, 7'h00, 1, 3, 1, 0, 0, 1);
        step("done_pulse", 0, IDLE, 1, 7'h00, 0, 3, 1, 0, 0, 0);

        // Simultaneous presses
        step("left_right", 0, LR, 1, 7'h00, 0, 3, 1, 0, 0, 0);
        step("left_drop", 0, LD, 1, 7'h00, 0, 3, 1, 1, 3, 0);
        step("accept2", 0, IDLE, 1, 7'h00, 1, 3, 0, 0, 0, 1);

        // All columns full: nothing moves, nothing drops
        step("full_drop", 0, DROP, 1, 7'h7F, 0, 3, 0, 0, 0, 0);
        step("full_left", 0, LEFT, 1, 7'h7F, 0, 3, 0, 0, 0, 0);
        step("full_right", 0, RIGHT, 1, 7'h7F, 0, 3, 0, 0, 0, 0);
        step("full_idle", 0, IDLE, 1, 7'h7F, 0, 3, 0, 0, 0, 0);

        // Auto-advance off a full cursor column
        step("auto_adv", 0, IDLE, 1, 7'b0001000, 0, 4, 0, 0, 0, 0);
        step("auto_hold", 0, IDLE, 1, 7'b0001000, 0, 4, 0, 0, 0, 0);

        // Drop, return to a full START_COL, then auto-advance
        step("drop4", 0, DROP, 1, 7'b0001000, 0, 4, 0, 1, 4, 0);
        step("accept4", 0, IDLE, 1, 7'b0001000, 1, 3, 1, 0, 0, 1);
        step("reloc", 0, IDLE, 1, 7'b0001000, 0, 4, 1, 0, 0, 0);

        // Gating with game_active=0
        step("gate_left", 0, LEFT, 0, 7'h00, 0, 4, 1, 0, 0, 0);
        step("gate_drop", 0, DROP, 0, 7'h00, 0, 4, 1, 0, 0, 0);
        step("gate_auto", 0, IDLE, 0, 7'b0010000, 0, 4, 1, 0, 0, 0);
        step("ungate_auto", 0, IDLE, 1, 7'b0010000, 0, 5, 1, 0, 0, 0);
        step("drop5", 0, DROP, 1, 7'b0010000, 0, 5, 1, 1, 5, 0);
        step("hold_inactive", 0, LEFT, 0, 7'b0010000, 0, 5, 1, 1, 5, 0);

        // Reset mid-handshake
        step("rst_in_drop", 1, IDLE, 1, 7'h00, 1, 3, 0, 0, 0, 0);
        step("post_rst", 0, IDLE, 1, 7'h00, 0, 3, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
